// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch vs. load/store) in front of a shared
// single-port RAM with 1-cycle read latency; loads/stores win unless fetch is starved.
module mem_port_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int STARVE_MAX = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [31:0]       ls_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_wren,
   input  logic [31:0]       mem_q
);

   localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt;
   logic [1:0]       owner;      // {load in flight, fetch in flight}
   logic             ls_win;

   // LSU wins contention until fetch has lost STARVE_MAX times in a row
   always_comb begin
      ls_win = ls_req & (~if_req | (starve_cnt < CNT_MAX));
      ls_gnt = ~reset & ls_win;
      if_gnt = ~reset & if_req & ~ls_win;
   end

   always_ff @(posedge clk) begin
      if (reset || !if_req || if_gnt) begin
         starve_cnt <= '0;
      end else if (ls_gnt && (starve_cnt < CNT_MAX)) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) owner <= 2'b00;
      else       owner <= {ls_gnt & ~ls_we, if_gnt};
   end

   // Gate with reset so a read granted just before reset never returns
   assign if_rvalid = owner[0] & ~reset;
   assign ls_rvalid = owner[1] & ~reset;
   assign if_rdata  = mem_q;
   assign ls_rdata  = mem_q;

   assign mem_addr  = ls_gnt ? ls_addr : if_addr;
   assign mem_wdata = ls_wdata;
   assign mem_wren  = ls_gnt & ls_we;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter against a transaction-level
// model with a shadow memory and an expected-read-return slot per port.
module tb_mem_port_arbiter;
   localparam int AW = 12;
   localparam int SM = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req, if_gnt, if_rvalid;
   logic [AW-1:0] if_addr;
   logic [31:0]   if_rdata;
   logic          ls_req, ls_we, ls_gnt, ls_rvalid;
   logic [AW-1:0] ls_addr;
   logic [31:0]   ls_wdata, ls_rdata;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_q;
   logic          mem_wren;

   mem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
      .mem_q(mem_q)
   );

   always #5 clk = ~clk;

   // RAM environment: registered address, read-first, 1-cycle latency
   logic [31:0] ram    [0:(1<<AW)-1];
   logic [31:0] shadow [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_wren) ram[mem_addr] <= mem_wdata;
      mem_q <= ram[mem_addr];
   end

   int checks = 0, failures = 0;
   int streak = 0;
   bit g_if, g_ls, p_if, p_ls;
   logic [31:0] p_if_d, p_ls_d;
   logic o_if_gnt, o_ls_gnt, o_if_rv, o_ls_rv, o_wren;
   logic [31:0] o_if_rd, o_ls_rd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: decides the grant from the fetch-starvation streak, checks the
   // DUT, then advances shadow memory and the expected read returns.
   task automatic model_cycle();
      bit exp_if_rv, exp_ls_rv;
      g_if = 1'b0; g_ls = 1'b0;
      if (!reset) begin
         if (ls_req && (!if_req || streak < SM)) g_ls = 1'b1;
         else if (if_req)                        g_if = 1'b1;
      end
      exp_if_rv = p_if && !reset;
      exp_ls_rv = p_ls && !reset;
      o_if_gnt = if_gnt; o_ls_gnt = ls_gnt; o_if_rv = if_rvalid; o_ls_rv = ls_rvalid;
      o_if_rd = if_rdata; o_ls_rd = ls_rdata; o_wren = mem_wren;
      chk("if_gnt",    32'(if_gnt),    32'(g_if));
      chk("ls_gnt",    32'(ls_gnt),    32'(g_ls));
      chk("mem_wren",  32'(mem_wren),  32'(g_ls && ls_we));
      chk("mem_addr",  32'(mem_addr),  32'(g_ls ? ls_addr : if_addr));
      chk("mem_wdata", mem_wdata,      ls_wdata);
      chk("if_rvalid", 32'(if_rvalid), 32'(exp_if_rv));
      chk("ls_rvalid", 32'(ls_rvalid), 32'(exp_ls_rv));
      if (exp_if_rv) chk("if_rdata", if_rdata, p_if_d);
      if (exp_ls_rv) chk("ls_rdata", ls_rdata, p_ls_d);
      p_if   = g_if;
      p_if_d = shadow[if_addr];
      p_ls   = g_ls && !ls_we;
      p_ls_d = shadow[ls_addr];
      if (g_ls && ls_we) shadow[ls_addr] = ls_wdata;
      if (reset || !if_req || g_if) streak = 0;
      else if (g_ls && streak < SM) streak++;
   endtask

   task automatic step();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit r, input bit ir, input logic [AW-1:0] ia,
                        input bit lr, input bit we, input logic [AW-1:0] la,
                        input logic [31:0] wd);
      reset = r; if_req = ir; if_addr = ia;
      ls_req = lr; ls_we = we; ls_addr = la; ls_wdata = wd;
   endtask

   initial begin
      logic [5:0] seq;
      int gcnt, rvcnt;
      for (int i = 0; i < (1<<AW); i++) begin
         ram[i] = $urandom; shadow[i] = ram[i];
      end
      ram[12'h010] = 32'h00500093; shadow[12'h010] = 32'h00500093;
      drive(1, 0, '0, 0, 0, '0, '0);
      repeat (3) step();
      chk("reset_if_gnt", 32'(o_if_gnt), 32'd0);
      chk("reset_ls_rv",  32'(o_ls_rv),  32'd0);

      // single fetch: data returns the next cycle
      drive(0, 1, 12'h010, 0, 0, '0, '0); step();
      chk("fetch_gnt", 32'(o_if_gnt), 32'd1);
      drive(0, 0, '0, 0, 0, '0, '0); step();
      chk("fetch_rv",   32'(o_if_rv), 32'd1);
      chk("fetch_data", o_if_rd, 32'h00500093);

      // store then load same address
      drive(0, 0, '0, 1, 1, 12'h020, 32'hDEADBEEF); step();
      chk("st_wren", 32'(o_wren), 32'd1);
      drive(0, 0, '0, 1, 0, 12'h020, '0); step();
      chk("st_no_rv", 32'(o_ls_rv), 32'd0);
      chk("ld_wren",  32'(o_wren),  32'd0);
      drive(0, 0, '0, 0, 0, '0, '0); step();
      chk("ld_rv",   32'(o_ls_rv), 32'd1);
      chk("ld_data", o_ls_rd, 32'hDEADBEEF);

      // held contention: LS LS IF LS LS IF
      seq = '0;
      drive(0, 1, 12'h040, 1, 0, 12'h041, '0);
      for (int i = 0; i < 6; i++) begin
         step(); seq = {seq[4:0], o_ls_gnt};
      end
      chk("starve_seq", 32'(seq), 32'(6'b110110));
      drive(0, 0, '0, 0, 0, '0, '0); step();

      // alternating back-to-back reads
      gcnt = 0; rvcnt = 0;
      for (int i = 0; i < 9; i++) begin
         if (i == 8)          drive(0, 0, '0, 0, 0, '0, '0);
         else if (i % 2 == 0) drive(0, 1, AW'(12'h100 + i), 0, 0, '0, '0);
         else                 drive(0, 0, '0, 1, 0, AW'(12'h200 + i), '0);
         step();
         gcnt  += int'(o_if_gnt | o_ls_gnt);
         rvcnt += int'(o_if_rv | o_ls_rv);
      end
      chk("alt_grants", 32'(gcnt),  32'd8);
      chk("alt_rvalid", 32'(rvcnt), 32'd8);

      // fetch right before reset must not return
      drive(0, 1, 12'h010, 0, 0, '0, '0); step();
      drive(1, 1, 12'h010, 0, 0, '0, '0); step();
      chk("rst_kill_rv", 32'(o_if_rv), 32'd0);
      step();
      drive(0, 0, '0, 0, 0, '0, '0); step();
      chk("post_rst_rv", 32'(o_if_rv), 32'd0);

      // dropping if_req clears the starvation streak
      drive(0, 1, 12'h050, 1, 0, 12'h051, '0); step(); step();
      drive(0, 0, 12'h050, 0, 0, 12'h051, '0); step();
      drive(0, 1, 12'h050, 1, 0, 12'h051, '0); step();
      chk("streak_clr", 32'(o_ls_gnt), 32'd1);
      drive(0, 0, '0, 0, 0, '0, '0); step();

      // random requesters that hold each request until it is granted
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         if (!if_req || g_if) begin
            if_req  = ($urandom_range(0, 3) != 0);
            if_addr = AW'($urandom_range(0, 63));
         end
         if (!ls_req || g_ls) begin
            ls_req   = ($urandom_range(0, 2) != 0);
            ls_we    = $urandom_range(0, 1);
            ls_addr  = AW'($urandom_range(0, 63));
            ls_wdata = $urandom;
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
